// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for branch resolution: condition codes, flag
// bit positions, resolver states and the condition evaluator.
package branch_resolve_unit_pkg;

    localparam logic [3:0] COND_NONE = 4'b0000;
    localparam logic [3:0] COND_BLTZ = 4'b0001;
    localparam logic [3:0] COND_BZ   = 4'b0010;
    localparam logic [3:0] COND_BNZ  = 4'b0011;
    localparam logic [3:0] COND_BCY  = 4'b0100;
    localparam logic [3:0] COND_BNCY = 4'b0101;
    localparam logic [3:0] COND_BGEZ = 4'b0110;
    localparam logic [3:0] COND_BV   = 4'b0111;
    localparam logic [3:0] COND_B    = 4'b1000;
    localparam logic [3:0] COND_CALL = 4'b1001;
    localparam logic [3:0] COND_RET  = 4'b1010;

    localparam int FLAG_S = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    // ret is resolved against the stack, not the flags.
    function automatic logic cond_met(
        input logic [3:0] c,
        input logic [3:0] f
    );
        case (c)
            COND_BLTZ: cond_met = f[FLAG_S];
            COND_BZ:   cond_met = f[FLAG_Z];
            COND_BNZ:  cond_met = !f[FLAG_Z];
            COND_BCY:  cond_met = f[FLAG_C];
            COND_BNCY: cond_met = !f[FLAG_C];
            COND_BGEZ: cond_met = !f[FLAG_S];
            COND_BV:   cond_met = f[FLAG_V];
            COND_B:    cond_met = 1'b1;
            COND_CALL: cond_met = 1'b1;
            default:   cond_met = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_resolve_unit_ras.sv
// Circular return-address stack; a push onto a full stack
// overwrites the oldest entry.
module ras_stack #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  top_idx;
    logic [CNT_W-1:0]  count;

    assign top_idx = ptr - PTR_W'(1);
    assign top     = mem[top_idx];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (!full)
                count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[ptr] <= din;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branch-class instructions against the flags or the
// return-address stack and issues a redirect plus flush bubbles.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int RAS_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [3:0]        cond,
    input  logic [3:0]        flags_in,
    input  logic              flags_we,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic [ADDR_W-1:0] target_in,
    output logic              taken,
    output logic [ADDR_W-1:0] target_out,
    output logic              flush,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        flags_q;
    logic [3:0]        eff_flags;
    logic              eval;
    logic              is_call;
    logic              is_ret;
    logic              ras_push;
    logic              ras_pop;
    logic              ras_full;
    logic              ras_empty;
    logic [ADDR_W-1:0] ras_top;
    logic              res_taken;
    logic [ADDR_W-1:0] res_target;

    assign eff_flags = flags_we ? flags_in : flags_q;
    assign eval      = valid && (state == ST_IDLE);
    assign is_call   = (cond == COND_CALL);
    assign is_ret    = (cond == COND_RET);
    assign ras_push  = eval && is_call;
    assign ras_pop   = eval && is_ret && !ras_empty;

    assign res_taken = eval &&
        (is_ret ? !ras_empty : cond_met(cond, eff_flags));
    assign res_target = is_ret ? ras_top : target_in;

    ras_stack #(
        .ADDR_W(ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk  (clk),
        .rst  (rst),
        .push (ras_push),
        .pop  (ras_pop),
        .din  (pc_next),
        .top  (ras_top),
        .full (ras_full),
        .empty(ras_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags_q <= '0;
        else if (flags_we)
            flags_q <= flags_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            if (ras_push && ras_full)
                ras_overflow <= 1'b1;
            if (eval && is_ret && ras_empty)
                ras_underflow <= 1'b1;
        end
    end

    // cnt holds the flush cycles still owed after the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            taken      <= 1'b0;
            flush      <= 1'b0;
            target_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    taken <= res_taken;
                    flush <= res_taken;
                    if (res_taken) begin
                        target_out <= res_target;
                        cnt        <= CNT_W'(FLUSH_CYCLES - 1);
                        state      <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    taken <= 1'b0;
                    if (cnt == '0) begin
                        flush <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: table of single-branch vectors plus hand-written
// RAS, back-to-back and reset-abort sequences.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [3:0]  cond;
    logic [3:0]  flags_in;
    logic        flags_we;
    logic [31:0] pc_next;
    logic [31:0] target_in;
    logic        taken;
    logic [31:0] target_out;
    logic        flush;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .ADDR_W      (32),
        .RAS_DEPTH   (4),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid),
        .cond         (cond),
        .flags_in     (flags_in),
        .flags_we     (flags_we),
        .pc_next      (pc_next),
        .target_in    (target_in),
        .taken        (taken),
        .target_out   (target_out),
        .flush        (flush),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    typedef struct packed {
        logic [3:0]  pre;
        logic        we;
        logic [3:0]  fin;
        logic [3:0]  cond;
        logic [31:0] tgt;
        logic        exp_taken;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid    = 1'b0;
        flags_we = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One instruction, then valid low through the flush window.
    task automatic issue(input logic [3:0] c, input logic [31:0] pc,
                         input logic [31:0] tgt, output logic t,
                         output logic [31:0] tout);
        valid     = 1'b1;
        cond      = c;
        pc_next   = pc;
        target_in = tgt;
        tick();
        t    = taken;
        tout = target_out;
        valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] last_tgt;
        logic        t;
        logic [31:0] tout;

        vecs[0]  = '{4'b0000, 1'b1, 4'b0010, 4'b0010, 32'h40, 1'b1};
        vecs[1]  = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 32'h44, 1'b0};
        vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 4'b1000, 32'h80, 1'b1};
        vecs[3]  = '{4'b0001, 1'b0, 4'b0000, 4'b0001, 32'h10, 1'b1};
        vecs[4]  = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 32'h14, 1'b0};
        vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 4'b0011, 32'h18, 1'b1};
        vecs[6]  = '{4'b0100, 1'b0, 4'b0000, 4'b0100, 32'h1c, 1'b1};
        vecs[7]  = '{4'b0000, 1'b0, 4'b0000, 4'b0101, 32'h20, 1'b1};
        vecs[8]  = '{4'b0100, 1'b0, 4'b0000, 4'b0101, 32'h24, 1'b0};
        vecs[9]  = '{4'b0001, 1'b0, 4'b0000, 4'b0110, 32'h28, 1'b0};
        vecs[10] = '{4'b0000, 1'b0, 4'b0000, 4'b0110, 32'h2c, 1'b1};
        vecs[11] = '{4'b1000, 1'b0, 4'b0000, 4'b0111, 32'h30, 1'b1};
        vecs[12] = '{4'b0111, 1'b0, 4'b0000, 4'b0111, 32'h34, 1'b0};
        vecs[13] = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 32'h38, 1'b0};
        vecs[14] = '{4'b1111, 1'b0, 4'b0000, 4'b1011, 32'h3c, 1'b0};
        vecs[15] = '{4'b0010, 1'b1, 4'b0000, 4'b0010, 32'h48, 1'b0};

        rst = 1'b1; valid = 1'b0; cond = '0; flags_in = '0;
        flags_we = 1'b0; pc_next = '0; target_in = '0;
        #12;
        check("rst_taken", {31'd0, taken}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_target", target_out, 32'd0);
        check("rst_ovf", {31'd0, ras_overflow}, 32'd0);
        check("rst_unf", {31'd0, ras_underflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        last_tgt = 32'd0;
        for (int i = 0; i < 16; i++) begin
            valid = 1'b0; flags_we = 1'b1; flags_in = vecs[i].pre;
            tick();
            flags_we  = vecs[i].we;
            flags_in  = vecs[i].fin;
            valid     = 1'b1;
            cond      = vecs[i].cond;
            target_in = vecs[i].tgt;
            tick();
            if (vecs[i].exp_taken) last_tgt = vecs[i].tgt;
            check($sformatf("v%0d_taken", i), {31'd0, taken},
                  {31'd0, vecs[i].exp_taken});
            check($sformatf("v%0d_target", i), target_out, last_tgt);
            check($sformatf("v%0d_flush0", i), {31'd0, flush},
                  {31'd0, vecs[i].exp_taken});
            valid = 1'b0; flags_we = 1'b0;
            tick();
            check($sformatf("v%0d_pulse", i), {31'd0, taken}, 32'd0);
            check($sformatf("v%0d_flush1", i), {31'd0, flush},
                  {31'd0, vecs[i].exp_taken});
            tick();
            check($sformatf("v%0d_flush2", i), {31'd0, flush}, 32'd0);
        end

        // nested call/ret and underflow
        do_reset();
        issue(4'b1001, 32'h11, 32'h100, t, tout);
        check("c1_taken", {31'd0, t}, 32'd1);
        check("c1_target", tout, 32'h100);
        issue(4'b1001, 32'h22, 32'h200, t, tout);
        issue(4'b1010, 32'h0, 32'h0, t, tout);
        check("r1_taken", {31'd0, t}, 32'd1);
        check("r1_target", tout, 32'h22);
        issue(4'b1010, 32'h0, 32'h0, t, tout);
        check("r2_target", tout, 32'h11);
        issue(4'b1010, 32'h0, 32'h0, t, tout);
        check("r3_taken", {31'd0, t}, 32'd0);
        check("r3_target", tout, 32'h11);
        check("r3_unf", {31'd0, ras_underflow}, 32'd1);
        check("r3_ovf", {31'd0, ras_overflow}, 32'd0);

        // overflow wraps onto oldest entry
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(4'b1001, 32'h31 + i, 32'h300, t, tout);
            check($sformatf("ov_call%0d", i), {31'd0, t}, 32'd1);
            check($sformatf("ov_flag%0d", i), {31'd0, ras_overflow},
                  (i == 4) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            issue(4'b1010, 32'h0, 32'h0, t, tout);
            check($sformatf("ov_ret%0d", i), tout, 32'h35 - i);
        end
        check("ov_unf_before", {31'd0, ras_underflow}, 32'd0);
        issue(4'b1010, 32'h0, 32'h0, t, tout);
        check("ov_ret_empty", {31'd0, t}, 32'd0);
        check("ov_unf_after", {31'd0, ras_underflow}, 32'd1);

        // back-to-back calls: squashed ones must not push
        do_reset();
        valid = 1'b1; cond = 4'b1001; target_in = 32'h500;
        for (int i = 0; i < 9; i++) begin
            pc_next = 32'h50 + i;
            tick();
            check($sformatf("bb_taken%0d", i), {31'd0, taken},
                  (i % 3 == 0) ? 32'd1 : 32'd0);
            check($sformatf("bb_flush%0d", i), {31'd0, flush},
                  (i % 3 != 2) ? 32'd1 : 32'd0);
        end
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(4'b1010, 32'h0, 32'h0, t, tout);
            check($sformatf("bb_ret%0d", i), tout, 32'h56 - 3 * i);
        end
        issue(4'b1010, 32'h0, 32'h0, t, tout);
        check("bb_ret_empty", {31'd0, t}, 32'd0);

        // reset aborts flush
        do_reset();
        valid = 1'b1; cond = 4'b1000; target_in = 32'h90;
        tick();
        check("ra_taken", {31'd0, taken}, 32'd1);
        valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("ra_taken_rst", {31'd0, taken}, 32'd0);
        check("ra_flush_rst", {31'd0, flush}, 32'd0);
        check("ra_target_rst", target_out, 32'd0);
        valid = 1'b1; cond = 4'b1000; target_in = 32'ha0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("ra_post_taken", {31'd0, taken}, 32'd1);
        check("ra_post_target", target_out, 32'ha0);
        check("ra_post_flush", {31'd0, flush}, 32'd1);
        valid = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter ADDR_W, default 32, width of all program addresses.
REQ-002 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-003 Parameter FLUSH_CYCLES, default 2, bubble cycles after a taken branch (>=1).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 valid  input  1  a branch-class instruction is presented this cycle.
REQ-007 cond  input  4  condition code of the presented instruction.
REQ-008 flags_in  input  4  {overflow, carry, zero, sign} from ALU.
REQ-009 flags_we  input  1  write flags_in into the flag register.
REQ-010 pc_next  input  ADDR_W  return address (PC+1) of the presented instruction.
REQ-011 target_in  input  ADDR_W  decoded branch target.
REQ-012 taken  output  1  registered, branch resolved taken.
REQ-013 target_out  output  ADDR_W  registered, redirect address, valid when taken=1.
REQ-014 flush  output  1  registered, squash fetch/decode this cycle.
REQ-015 ras_overflow  output  1  sticky, call pushed onto a full stack.
REQ-016 ras_underflow  output  1  sticky, ret popped an empty stack.

Function
REQ-017 Condition encoding SHALL be: 0000 none; 0001 bltz (sign=1); 0010 bz (zero=1); 0011 bnz (zero=0); 0100 bcy (carry=1); 0101 bncy (carry=0); 0110 bgez (sign=0); 0111 bv (overflow=1); 1000 b (always); 1001 call (always, push); 1010 ret (pop); 1011-1111 never taken.
REQ-018 Evaluation SHALL use flags_in when flags_we=1 in the same cycle (bypass), else the flag register.
REQ-019 The flag register SHALL load flags_in on every cycle with flags_we=1, including during flush.
REQ-020 A qualifying instruction (valid=1, state IDLE) SHALL produce taken/target_out on the next rising edge (latency 1); taken SHALL be a single-cycle pulse.
REQ-021 target_out SHALL be target_in for conditional/b/call, and the stack top for ret.
REQ-022 call SHALL push pc_next; on a full stack the oldest entry is overwritten (circular), ras_overflow set, taken still 1.
REQ-023 ret on an empty stack SHALL be not taken, target_out unchanged, ras_underflow set, no pointer change.
REQ-024 State machine: IDLE -> FLUSH on a taken resolution; FLUSH counts FLUSH_CYCLES cycles then returns to IDLE.
REQ-025 flush SHALL be 1 in exactly FLUSH_CYCLES consecutive cycles, the first coinciding with taken=1.
REQ-026 In FLUSH, valid SHALL be ignored: no evaluation, no push/pop, taken=0.
REQ-027 Not-taken or non-branch instructions SHALL leave state IDLE, taken=0, flush=0, stack unchanged.
REQ-028 Stack pointer and occupancy count SHALL be modulo RAS_DEPTH arithmetic; count saturates at RAS_DEPTH.

Reset
REQ-029 rst=1 SHALL asynchronously force: taken=0, flush=0, target_out=0, flags=0000, stack empty, pointer 0, sticky errors 0, state IDLE.
REQ-030 rst asserted mid-flush SHALL abort the flush immediately; first post-reset edge with valid=1 evaluates normally.

Structure
REQ-031 Condition-code constants, flag bit indices and the state enum SHALL live in a shared package used by decoder and this block.
REQ-032 The return-address stack SHALL be one sub-module, ras_stack (push, pop, top, full, empty).

Verification
REQ-033 flags_we=1 flags_in=0010, same cycle valid cond=0010 target_in=0x40 -> next edge taken=1, target_out=0x40, flush high 2 cycles.
REQ-034 Flag reg zero=0, valid cond=0010 -> taken=0, flush=0; cond=1000 target_in=0x80 -> taken=1, target_out=0x80.
REQ-035 call pc_next=0x11, wait flush, call pc_next=0x22, wait, ret, wait, ret -> targets 0x22 then 0x11; third ret -> taken=0, ras_underflow=1.
REQ-036 Five calls with RAS_DEPTH=4 -> ras_overflow=1; four rets return the last four pc_next values newest first.
REQ-037 valid cond=1000 on every cycle -> taken pulses once per FLUSH_CYCLES+1 cycles; squashed instructions cause no push/pop.
REQ-038 rst asserted in first flush cycle -> taken=0, flush=0 at once; next valid cond=1000 resolves taken one edge after rst release.
